// File: rtl/sobel_pkg.sv
// Shared types for the pipelined Sobel core: mode encodings, gradient width
// derivation and the payload carried alongside each beat through the pipeline.
package sobel_pkg;

  function automatic int sobel_gw(input int pix_w);
    return pix_w + 3;
  endfunction

  // Payload fields are sized for the widest supported configuration; each
  // instance narrows them with size casts.
  localparam int SOBEL_PIX_W_MAX   = 16;
  localparam int SOBEL_COORD_W_MAX = 16;
  localparam int SOBEL_GW_MAX      = sobel_gw(SOBEL_PIX_W_MAX);

  typedef enum logic [1:0] {
    SOBEL_BIN     = 2'd0,
    SOBEL_L1      = 2'd1,
    SOBEL_LINF    = 2'd2,
    SOBEL_BIN_ALT = 2'd3
  } sobel_mode_e;

  typedef struct packed {
    logic signed [SOBEL_GW_MAX-1:0]      gx;
    logic signed [SOBEL_GW_MAX-1:0]      gy;
    logic        [SOBEL_COORD_W_MAX-1:0] col;
    logic        [SOBEL_COORD_W_MAX-1:0] row;
    sobel_mode_e                         mode;
    logic        [SOBEL_GW_MAX-1:0]      thresh;
  } sobel_stage_t;

endpackage

// File: rtl/sobel_grad.sv
// Combinational 3x3 Sobel kernels: unsigned window in, signed Gx/Gy out.
module sobel_grad
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic        [PIX_W-1:0]           data_0_0_i,
  input  logic        [PIX_W-1:0]           data_0_1_i,
  input  logic        [PIX_W-1:0]           data_0_2_i,
  input  logic        [PIX_W-1:0]           data_1_0_i,
  input  logic        [PIX_W-1:0]           data_1_2_i,
  input  logic        [PIX_W-1:0]           data_2_0_i,
  input  logic        [PIX_W-1:0]           data_2_1_i,
  input  logic        [PIX_W-1:0]           data_2_2_i,
  output logic signed [sobel_gw(PIX_W)-1:0] gx_o,
  output logic signed [sobel_gw(PIX_W)-1:0] gy_o
);

  localparam int GW = sobel_gw(PIX_W);

  logic [GW-1:0] x_pos;
  logic [GW-1:0] x_neg;
  logic [GW-1:0] y_pos;
  logic [GW-1:0] y_neg;

  // Each weighted column/row sum is at most 4*(2^PIX_W-1), so the unsigned
  // partial sums and their difference never overflow GW bits.
  always_comb begin
    x_pos = GW'(data_0_2_i) + (GW'(data_1_2_i) << 1) + GW'(data_2_2_i);
    x_neg = GW'(data_0_0_i) + (GW'(data_1_0_i) << 1) + GW'(data_2_0_i);
    y_pos = GW'(data_0_0_i) + (GW'(data_0_1_i) << 1) + GW'(data_0_2_i);
    y_neg = GW'(data_2_0_i) + (GW'(data_2_1_i) << 1) + GW'(data_2_2_i);
    gx_o  = $signed(x_pos - x_neg);
    gy_o  = $signed(y_pos - y_neg);
  end

endmodule

// File: rtl/sobel_core_pipe.sv
// Three-stage pipelined Sobel core with valid/ready backpressure, binary or
// saturated-magnitude output and a saturating per-frame edge counter.
module sobel_core_pipe
  import sobel_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int COORD_W = 10,
  parameter int CNT_W   = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIX_W-1:0]           data_0_0_i,
  input  logic [PIX_W-1:0]           data_0_1_i,
  input  logic [PIX_W-1:0]           data_0_2_i,
  input  logic [PIX_W-1:0]           data_1_0_i,
  input  logic [PIX_W-1:0]           data_1_1_i,
  input  logic [PIX_W-1:0]           data_1_2_i,
  input  logic [PIX_W-1:0]           data_2_0_i,
  input  logic [PIX_W-1:0]           data_2_1_i,
  input  logic [PIX_W-1:0]           data_2_2_i,
  input  logic                       core_en_i,
  output logic                       core_rdy_o,
  input  logic [COORD_W-1:0]         cnt_col_i,
  input  logic [COORD_W-1:0]         cnt_row_i,
  input  logic [1:0]                 mode_i,
  input  logic [sobel_gw(PIX_W)-1:0] thresh_i,
  input  logic                       cnt_clr_i,
  output logic [PIX_W-1:0]           pixel_o,
  output logic                       core_en_o,
  input  logic                       core_rdy_i,
  output logic [COORD_W-1:0]         cnt_col_o,
  output logic [COORD_W-1:0]         cnt_row_o,
  output logic [CNT_W-1:0]           edge_cnt_o
);

  localparam int GW = sobel_gw(PIX_W);

  logic signed [GW-1:0] gx;
  logic signed [GW-1:0] gy;
  logic                 adv;

  logic         s1_vld_q, s1_vld_d;
  logic         s2_vld_q, s2_vld_d;
  sobel_stage_t s1_q, s1_d;
  sobel_stage_t s2_q, s2_d;

  logic               core_en_q, core_en_d;
  logic [PIX_W-1:0]   pixel_q, pixel_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;

  logic [GW-1:0]    gx_s1, gy_s1, abs_x, abs_y;
  logic [GW-1:0]    mag_x, mag_y, mag_sum, mag_max, thr_s2;
  logic [PIX_W-1:0] pix_res;
  logic             edge_hs;

  function automatic logic [PIX_W-1:0] sat_pix(input logic [GW-1:0] v);
    return (|v[GW-1:PIX_W]) ? '1 : v[PIX_W-1:0];
  endfunction

  sobel_grad #(.PIX_W(PIX_W)) u_grad (
    .data_0_0_i (data_0_0_i),
    .data_0_1_i (data_0_1_i),
    .data_0_2_i (data_0_2_i),
    .data_1_0_i (data_1_0_i),
    .data_1_2_i (data_1_2_i),
    .data_2_0_i (data_2_0_i),
    .data_2_1_i (data_2_1_i),
    .data_2_2_i (data_2_2_i),
    .gx_o       (gx),
    .gy_o       (gy)
  );

  // The centre pixel has zero weight in both kernels.
  logic unused_center;
  assign unused_center = ^data_1_1_i;

  // Every stage moves together; a held output freezes the whole pipe.
  assign adv        = ~core_en_q | core_rdy_i;
  assign core_rdy_o = adv;

  // S2 magnitudes and S3 result selection, computed from the registered stages.
  always_comb begin
    gx_s1   = GW'(s1_q.gx);
    gy_s1   = GW'(s1_q.gy);
    abs_x   = gx_s1[GW-1] ? -gx_s1 : gx_s1;
    abs_y   = gy_s1[GW-1] ? -gy_s1 : gy_s1;
    mag_x   = GW'(s2_q.gx);
    mag_y   = GW'(s2_q.gy);
    thr_s2  = GW'(s2_q.thresh);
    mag_sum = mag_x + mag_y;
    mag_max = (mag_x > mag_y) ? mag_x : mag_y;
    case (s2_q.mode)
      SOBEL_L1:   pix_res = sat_pix(mag_sum);
      SOBEL_LINF: pix_res = sat_pix(mag_max);
      default:    pix_res = (mag_sum > thr_s2) ? '1 : '0;
    endcase
  end

  // NOTE: every always_comb target is given its hold value first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_d      = s1_q;
    s2_vld_d  = s2_vld_q;
    s2_d      = s2_q;
    core_en_d = core_en_q;
    pixel_d   = pixel_q;
    col_d     = col_q;
    row_d     = row_q;
    if (adv) begin
      s1_vld_d    = core_en_i;
      s1_d.gx     = SOBEL_GW_MAX'(gx);
      s1_d.gy     = SOBEL_GW_MAX'(gy);
      s1_d.col    = SOBEL_COORD_W_MAX'(cnt_col_i);
      s1_d.row    = SOBEL_COORD_W_MAX'(cnt_row_i);
      s1_d.mode   = sobel_mode_e'(mode_i);
      s1_d.thresh = SOBEL_GW_MAX'(thresh_i);

      // S2 reuses the payload; gx/gy now carry the absolute values.
      s2_vld_d = s1_vld_q;
      s2_d     = s1_q;
      s2_d.gx  = SOBEL_GW_MAX'(abs_x);
      s2_d.gy  = SOBEL_GW_MAX'(abs_y);

      core_en_d = s2_vld_q;
      if (s2_vld_q) begin
        pixel_d = pix_res;
        col_d   = COORD_W'(s2_q.col);
        row_d   = COORD_W'(s2_q.row);
      end
    end
  end

  always_comb begin
    edge_hs    = core_en_q & core_rdy_i & (|pixel_q);
    edge_cnt_d = edge_cnt_q;
    if (cnt_clr_i) begin
      edge_cnt_d = '0;
    end else if (edge_hs && (edge_cnt_q != '1)) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      core_en_q  <= 1'b0;
      pixel_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      edge_cnt_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      core_en_q  <= core_en_d;
      pixel_q    <= pixel_d;
      col_q      <= col_d;
      row_q      <= row_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  // NOTE: stage payloads carry no reset; the stage valid bits alone qualify them.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  assign core_en_o  = core_en_q;
  assign pixel_o    = pixel_q;
  assign cnt_col_o  = col_q;
  assign cnt_row_o  = row_q;
  assign edge_cnt_o = edge_cnt_q;

endmodule
